platform_scheduler: RTL

Per-frame controller that sequences the doodle physics datapath. Once per frame, at the start of vertical blank, it scans all on-screen platforms one per cycle and selects the landing ground for the doodle's feet. It then issues a single physics tick and tracks game state (idle / play / over). It sits between the platform store and the doodle block: it drives the doodle's `ground` input and replaces the doodle's free-running FPS counter with `frame_tick`.

---
 rtl/platform_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/platform_scheduler.sv
// Per-frame landing-ground scan and physics tick sequencer for the doodle datapath.
// Optional world scrolling is built only when PLATFORM_SCROLL_EN is defined.
module platform_scheduler #(
    parameter int NUM_PLATFORMS = 8,
    parameter int SCREEN_H      = 768,
    parameter int PLAT_W        = 100,
    parameter int DOODLE_H      = 80,
    parameter int SCROLL_LINE   = 300
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [10:0]                    beam_x,
    input  logic [9:0]                     beam_y,
    input  logic                           start,
    input  logic [NUM_PLATFORMS-1:0][10:0] plat_x,
    input  logic [NUM_PLATFORMS-1:0][9:0]  plat_y,
    input  logic [10:0]                    doodle_x,
    input  logic [9:0]                     doodle_y,
    output logic [1:0][9:0]                ground,
    output logic                           frame_tick,
    output logic [1:0]                     game_state,
    output logic [9:0]                     scroll_dy,
    output logic                           scroll_valid
);

    localparam int IDX_W = (NUM_PLATFORMS > 1) ? $clog2(NUM_PLATFORMS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PLATFORMS - 1);
    localparam logic [9:0] FLOOR_Y = 10'(SCREEN_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_SCAN = 2'd2,
        ST_OVER = 2'd3
    } state_t;

    state_t           state_r, state_n;
    logic [IDX_W-1:0] idx_r, idx_n;
    logic             best_found_r, best_found_n;
    logic [9:0]       best_y_r, best_y_n;
    logic [9:0]       best_x_r, best_x_n;
    logic [1:0][9:0]  ground_r, ground_n;
    logic             tick_r, tick_n;

    logic        vb_s;
    logic [11:0] slot_x_s, slot_y_s, feet_s, dx_s;
    logic        cand_s, take_s, sel_found_s;
    logic [9:0]  sel_y_s, sel_x_s;

    assign vb_s     = (beam_y == 10'(SCREEN_H)) && (beam_x == 11'd0);
    // All geometry is compared in 12 bits so the sums below cannot wrap.
    assign slot_x_s = {1'b0, plat_x[idx_r]};
    assign slot_y_s = {2'b00, plat_y[idx_r]};
    assign feet_s   = {2'b00, doodle_y} + 12'(DOODLE_H);
    assign dx_s     = {1'b0, doodle_x};
    assign cand_s   = (slot_y_s < 12'(SCREEN_H)) && (slot_y_s >= feet_s) &&
                      (slot_x_s <= dx_s) && (dx_s <= slot_x_s + 12'(PLAT_W - 1));
    // Strict less-than keeps the lower index on equal heights.
    assign take_s      = cand_s && (!best_found_r || (plat_y[idx_r] < best_y_r));
    assign sel_found_s = best_found_r || cand_s;
    assign sel_y_s     = take_s ? plat_y[idx_r] : best_y_r;
    assign sel_x_s     = take_s ? plat_x[idx_r][9:0] : best_x_r;

    // Next-state, scan bookkeeping and ground/tick decisions.
    always_comb begin
        state_n      = state_r;
        idx_n        = idx_r;
        best_found_n = best_found_r;
        best_y_n     = best_y_r;
        best_x_n     = best_x_r;
        ground_n     = ground_r;
        tick_n       = 1'b0;
        case (state_r)
            ST_IDLE: begin
                ground_n[0] = FLOOR_Y;
                ground_n[1] = 10'd0;
                if (start) begin
                    state_n = ST_PLAY;
                end else begin
                    state_n = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (vb_s) begin
                    state_n      = ST_SCAN;
                    idx_n        = '0;
                    best_found_n = 1'b0;
                    best_y_n     = 10'd0;
                    best_x_n     = 10'd0;
                end else begin
                    state_n = ST_PLAY;
                end
            end
            ST_SCAN: begin
                best_found_n = sel_found_s;
                best_y_n     = sel_y_s;
                best_x_n     = sel_x_s;
                if (idx_r == LAST_IDX) begin
                    idx_n = '0;
                    if (sel_found_s) begin
                        ground_n[0] = sel_y_s;
                        ground_n[1] = sel_x_s;
                        tick_n      = 1'b1;
                        state_n     = ST_PLAY;
                    end else if (feet_s < 12'(SCREEN_H)) begin
                        ground_n[0] = 10'h3FF;
                        ground_n[1] = 10'd0;
                        tick_n      = 1'b1;
                        state_n     = ST_PLAY;
                    end else begin
                        state_n = ST_OVER;
                    end
                end else begin
                    idx_n = idx_r + IDX_W'(1);
                end
            end
            ST_OVER: begin
                if (start) begin
                    state_n     = ST_IDLE;
                    ground_n[0] = FLOOR_Y;
                    ground_n[1] = 10'd0;
                end else begin
                    state_n = ST_OVER;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            idx_r        <= '0;
            best_found_r <= 1'b0;
            best_y_r     <= 10'd0;
            best_x_r     <= 10'd0;
            ground_r[0]  <= FLOOR_Y;
            ground_r[1]  <= 10'd0;
            tick_r       <= 1'b0;
        end else begin
            state_r      <= state_n;
            idx_r        <= idx_n;
            best_found_r <= best_found_n;
            best_y_r     <= best_y_n;
            best_x_r     <= best_x_n;
            ground_r     <= ground_n;
            tick_r       <= tick_n;
        end
    end

`ifdef PLATFORM_SCROLL_EN
    logic [9:0] scroll_dy_r;
    logic       scroll_valid_r;

    // Scroll amount is latched with each tick and held until the next one.
    always_ff @(posedge clk) begin
        if (rst) begin
            scroll_dy_r    <= 10'd0;
            scroll_valid_r <= 1'b0;
        end else begin
            scroll_valid_r <= 1'b0;
            if (tick_n) begin
                if (doodle_y < 10'(SCROLL_LINE)) begin
                    scroll_dy_r    <= 10'(SCROLL_LINE) - doodle_y;
                    scroll_valid_r <= 1'b1;
                end else begin
                    scroll_dy_r <= 10'd0;
                end
            end
        end
    end

    assign scroll_dy    = scroll_dy_r;
    assign scroll_valid = scroll_valid_r;
`else
    assign scroll_dy    = 10'd0;
    assign scroll_valid = 1'b0;
`endif

    assign ground     = ground_r;
    assign frame_tick = tick_r;
    assign game_state = state_r;

endmodule
